// File: rtl/sata_pkg.sv
// Shared definitions for the SATA DMA front end: walker state encoding,
// PRD entry layout and the word-address helper used to fetch entries.
package sata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAITD = 3'd2,
    ST_CHECK = 3'd3,
    ST_ISSUE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FIN   = 3'd6
  } prd_state_e;

  localparam logic [3:0]  PRD_OFS_DBA     = 4'd0;
  localparam logic [3:0]  PRD_OFS_DBAU    = 4'd4;
  localparam logic [3:0]  PRD_OFS_RSVD    = 4'd8;
  localparam logic [3:0]  PRD_OFS_DW3     = 4'd12;
  localparam logic [31:0] PRD_ENTRY_BYTES = 32'd16;

  localparam int unsigned PRD_DBC_MSB = 21;
  localparam int unsigned PRD_I_BIT   = 31;
  localparam int unsigned PRD_REM_W   = 23;

  // Byte address of word w of entry idx; the table base is 16-byte aligned.
  function automatic logic [31:0] prd_word_addr(input logic [31:0] base,
                                                input logic [15:0] idx,
                                                input logic [1:0]  w);
    logic [3:0] ofs;
    case (w)
      2'd0:    ofs = PRD_OFS_DBA;
      2'd1:    ofs = PRD_OFS_DBAU;
      2'd2:    ofs = PRD_OFS_RSVD;
      default: ofs = PRD_OFS_DW3;
    endcase
    return {base[31:4], 4'h0} + ({16'h0000, idx} * PRD_ENTRY_BYTES) + {28'h0000000, ofs};
  endfunction

endpackage

// File: rtl/prd_seg_calc.sv
// Segment sizing for the PRD walker: clips the remaining entry bytes to the
// maximum segment size and derives the end-of-command flag and next cursor.
module prd_seg_calc
  import sata_pkg::*;
#(
  parameter int unsigned C_MAX_XFER = 8192
) (
  input  logic [PRD_REM_W-1:0] remaining,
  input  logic [31:0]          addr,
  input  logic [15:0]          idx,
  input  logic [15:0]          prdtl,
  output logic [15:0]          seg_len,
  output logic                 seg_eof,
  output logic [31:0]          next_addr,
  output logic [PRD_REM_W-1:0] next_rem
);

  localparam logic [PRD_REM_W-1:0] MAX_LEN = PRD_REM_W'(C_MAX_XFER);

  logic fits_s;

  assign fits_s    = (remaining <= MAX_LEN);
  assign seg_len   = fits_s ? remaining[15:0] : MAX_LEN[15:0];
  assign seg_eof   = fits_s && (idx == (prdtl - 16'd1));
  assign next_addr = addr + {16'h0000, seg_len};
  assign next_rem  = remaining - {7'd0, seg_len};

endmodule

// File: rtl/prd_walker.sv
// AHCI PRD table walker: fetches 16-byte entries word by word, splits each
// entry into bounded DMA segments and tracks the PRDBC byte count.
module prd_walker
  import sata_pkg::*;
#(
  parameter int unsigned C_MAX_XFER = 8192
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic [31:0] cmd_prdt_base,
  input  logic [15:0] cmd_prdtl,
  input  logic        cmd_wrt,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [31:0] cmd_byte_cnt,
  output logic        prd_irq,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        dma_req,
  output logic [31:0] dma_address,
  output logic [15:0] dma_length,
  output logic        dma_wrt,
  output logic        dma_eof,
  input  logic        dma_ack
);

  prd_state_e state_q, state_d;
  logic [1:0]  w_q, w_d;
  logic [15:0] idx_q, idx_d, prdtl_q, prdtl_d;
  logic [31:0] base_q, base_d, dba_q, dba_d, dbau_q, dbau_d, addr_q, addr_d;
  logic [21:0] dbc_q, dbc_d;
  logic        irq_en_q, irq_en_d, abort_q, abort_d;
  logic [PRD_REM_W-1:0] rem_q, rem_d;

  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic [31:0] cnt_q, cnt_d, rd_addr_q, rd_addr_d, dma_addr_q, dma_addr_d;
  logic        rd_req_q, rd_req_d, dma_req_q, dma_req_d;
  logic [15:0] dma_len_q, dma_len_d;
  logic        dma_eof_q, dma_eof_d, dma_wrt_q, dma_wrt_d;

  logic [15:0]          seg_len_s;
  logic                 seg_eof_s;
  logic [31:0]          seg_next_addr_s;
  logic [PRD_REM_W-1:0] seg_next_rem_s;
  logic [32:0]          cnt_sum_s;
  logic                 take_s;

  prd_seg_calc #(.C_MAX_XFER(C_MAX_XFER)) u_seg (
    .remaining (rem_q),
    .addr      (addr_q),
    .idx       (idx_q),
    .prdtl     (prdtl_q),
    .seg_len   (seg_len_s),
    .seg_eof   (seg_eof_s),
    .next_addr (seg_next_addr_s),
    .next_rem  (seg_next_rem_s)
  );

  // A word is captured either in WAITD or when data rides along with the ack.
  assign take_s    = ((state_q == ST_WAITD) && rd_valid) ||
                     ((state_q == ST_FETCH) && rd_req_q && rd_ack && rd_valid);
  assign cnt_sum_s = {1'b0, cnt_q} + {17'd0, seg_len_s};

  // Next-state and next-output computation for the walker FSM.
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    idx_d      = idx_q;
    prdtl_d    = prdtl_q;
    base_d     = base_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    irq_d      = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    rd_req_d   = rd_req_q;
    rd_addr_d  = rd_addr_q;
    dma_req_d  = dma_req_q;
    dma_addr_d = dma_addr_q;
    dma_len_d  = dma_len_q;
    dma_eof_d  = dma_eof_q;
    dma_wrt_d  = dma_wrt_q;
    abort_d    = abort_q | (cmd_abort & (state_q != ST_IDLE));
    dba_d      = (take_s && (w_q == 2'd0)) ? {rd_data[31:1], 1'b0} : dba_q;
    dbau_d     = (take_s && (w_q == 2'd1)) ? rd_data : dbau_q;
    dbc_d      = (take_s && (w_q == 2'd3)) ? rd_data[PRD_DBC_MSB:0] : dbc_q;
    irq_en_d   = (take_s && (w_q == 2'd3)) ? rd_data[PRD_I_BIT] : irq_en_q;

    case (state_q)
      ST_IDLE: begin
        // A start landing on the done cycle belongs to the finished command.
        if (cmd_start && !done_q) begin
          base_d    = cmd_prdt_base;
          prdtl_d   = cmd_prdtl;
          dma_wrt_d = cmd_wrt;
          idx_d     = 16'd0;
          w_d       = 2'd0;
          cnt_d     = 32'd0;
          err_d     = 1'b0;
          abort_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = (cmd_prdtl == 16'd0) ? ST_FIN : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!rd_req_q) begin
          if (abort_q) begin
            state_d = ST_FIN;
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = prd_word_addr(base_q, idx_q, w_q);
          end
        end else if (rd_ack) begin
          rd_req_d = 1'b0;
          if (rd_valid) begin
            w_d     = w_q + 2'd1;
            state_d = (w_q == 2'd3) ? ST_CHECK : ST_FETCH;
          end else begin
            state_d = ST_WAITD;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAITD: begin
        if (rd_valid) begin
          w_d     = w_q + 2'd1;
          state_d = (w_q == 2'd3) ? ST_CHECK : ST_FETCH;
        end else begin
          state_d = ST_WAITD;
        end
      end
      ST_CHECK: begin
        if (abort_q) begin
          state_d = ST_FIN;
        end else if (dbau_q != 32'd0) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          rem_d   = {1'b0, dbc_q[21:1], 1'b1} + 23'd1;
          addr_d  = dba_q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!dma_req_q) begin
          dma_req_d  = 1'b1;
          dma_addr_d = addr_q;
          dma_len_d  = seg_len_s;
          dma_eof_d  = seg_eof_s;
        end else if (dma_ack) begin
          dma_req_d = 1'b0;
          addr_d    = seg_next_addr_s;
          rem_d     = seg_next_rem_s;
          cnt_d     = cnt_sum_s[32] ? 32'hFFFF_FFFF : cnt_sum_s[31:0];
          state_d   = ST_NEXT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_NEXT: begin
        if (abort_q) begin
          state_d = ST_FIN;
        end else if (rem_q != 23'd0) begin
          state_d = ST_ISSUE;
        end else begin
          irq_d   = irq_en_q;
          idx_d   = idx_q + 16'd1;
          w_d     = 2'd0;
          state_d = ((idx_q + 16'd1) == prdtl_q) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      w_q        <= 2'd0;
      idx_q      <= 16'd0;
      prdtl_q    <= 16'd0;
      base_q     <= 32'd0;
      dba_q      <= 32'd0;
      dbau_q     <= 32'd0;
      dbc_q      <= 22'd0;
      irq_en_q   <= 1'b0;
      abort_q    <= 1'b0;
      addr_q     <= 32'd0;
      rem_q      <= 23'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      cnt_q      <= 32'd0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 32'd0;
      dma_req_q  <= 1'b0;
      dma_addr_q <= 32'd0;
      dma_len_q  <= 16'd0;
      dma_eof_q  <= 1'b0;
      dma_wrt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      idx_q      <= idx_d;
      prdtl_q    <= prdtl_d;
      base_q     <= base_d;
      dba_q      <= dba_d;
      dbau_q     <= dbau_d;
      dbc_q      <= dbc_d;
      irq_en_q   <= irq_en_d;
      abort_q    <= abort_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      cnt_q      <= cnt_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      dma_req_q  <= dma_req_d;
      dma_addr_q <= dma_addr_d;
      dma_len_q  <= dma_len_d;
      dma_eof_q  <= dma_eof_d;
      dma_wrt_q  <= dma_wrt_d;
    end
  end

  assign cmd_busy     = busy_q;
  assign cmd_done     = done_q;
  assign cmd_err      = err_q;
  assign cmd_byte_cnt = cnt_q;
  assign prd_irq      = irq_q;
  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign dma_req      = dma_req_q;
  assign dma_address  = dma_addr_q;
  assign dma_length   = dma_len_q;
  assign dma_eof      = dma_eof_q;
  assign dma_wrt      = dma_wrt_q;

endmodule

// File: tb/tb_prd_walker.sv
// Bench for prd_walker: memory and DMA responders with random latency, and a
// reference model that derives segments, reads and counts from the PRD table.
module tb_prd_walker;

  localparam int unsigned MAXX  = 8192;
  localparam int          LIMIT = 20000;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic        eof;
  } seg_t;

  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        cmd_start = 1'b0, cmd_abort = 1'b0, cmd_wrt = 1'b0;
  logic [31:0] cmd_prdt_base = 32'd0;
  logic [15:0] cmd_prdtl = 16'd0;
  logic        cmd_busy, cmd_done, cmd_err, prd_irq, rd_req, dma_req, dma_wrt, dma_eof;
  logic [31:0] cmd_byte_cnt, rd_addr, dma_address;
  logic [15:0] dma_length;
  logic        rd_ack = 1'b0, rd_valid = 1'b0, dma_ack = 1'b0;
  logic [31:0] rd_data = 32'd0;

  prd_walker #(.C_MAX_XFER(MAXX)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_prdt_base(cmd_prdt_base), .cmd_prdtl(cmd_prdtl), .cmd_wrt(cmd_wrt),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .cmd_byte_cnt(cmd_byte_cnt),
    .prd_irq(prd_irq), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .dma_req(dma_req), .dma_address(dma_address),
    .dma_length(dma_length), .dma_wrt(dma_wrt), .dma_eof(dma_eof), .dma_ack(dma_ack)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return 32'h0;
  endfunction

  // Memory responder: random ack latency, data with or after the ack.
  int mem_lat_max = 0, vgap_max = 0, aw = -1, vw = -1, rd_viol = 0;
  logic [31:0] vdata = 32'd0;
  logic rd_ack_prev = 1'b0;
  logic [31:0] rd_seen [$];
  always @(negedge sys_clk) begin
    int g;
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = $urandom;
    if (sys_rst) begin
      aw = -1; vw = -1;
    end else begin
      if (rd_req && rd_ack_prev) rd_viol++;
      if (vw > 0) vw = vw - 1;
      else if (vw == 0) begin rd_valid = 1'b1; rd_data = vdata; vw = -1; end
      if (rd_req) begin
        if (aw < 0) aw = $urandom_range(mem_lat_max, 0);
        if (aw == 0) begin
          rd_ack = 1'b1; rd_seen.push_back(rd_addr); vdata = mrd(rd_addr); aw = -1;
          g = $urandom_range(vgap_max, 0);
          if (g == 0) begin rd_valid = 1'b1; rd_data = vdata; end
          else vw = g - 1;
        end else aw = aw - 1;
      end
    end
    rd_ack_prev = rd_ack;
  end

  // DMA responder: fixed or random acknowledge delay; records each segment.
  int dma_fixed = -1, dma_lat_max = 0, dw = -1, dma_viol = 0, ack_cyc = 0;
  logic dma_ack_prev = 1'b0;
  seg_t seg_seen [$];
  logic wrt_seen [$];
  always @(negedge sys_clk) begin
    seg_t s;
    dma_ack = 1'b0;
    if (sys_rst) begin
      dw = -1;
    end else if (dma_req) begin
      if (dma_ack_prev) dma_viol++;
      if (dw < 0) dw = (dma_fixed >= 0) ? dma_fixed : int'($urandom_range(dma_lat_max, 0));
      if (dw == 0) begin
        dma_ack = 1'b1; s.addr = dma_address; s.len = dma_length; s.eof = dma_eof;
        seg_seen.push_back(s); wrt_seen.push_back(dma_wrt); ack_cyc = cyc; dw = -1;
      end else dw = dw - 1;
    end
    dma_ack_prev = dma_ack;
  end

  int done_tot = 0, irq_tot = 0, done_cyc = 0;
  always @(negedge sys_clk) begin
    if (cmd_done) begin done_tot++; done_cyc = cyc; end
    if (prd_irq) irq_tot++;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_flags"}, {cmd_busy, cmd_done, cmd_err, prd_irq, rd_req, dma_req, dma_wrt, dma_eof}, 128'd0);
    chk({tag, "_data"}, {cmd_byte_cnt, rd_addr, dma_address, dma_length}, 128'd0);
  endtask

  task automatic put_entry(input logic [31:0] base, input int i, input logic [31:0] dba,
                           input logic [31:0] dbau, input logic [21:0] dbc, input logic irq);
    logic [31:0] eb;
    eb = {base[31:4], 4'h0} + 32'(i) * 32'd16;
    mem[eb] = dba; mem[eb + 32'd4] = dbau; mem[eb + 32'd8] = $urandom;
    mem[eb + 32'd12] = {irq, 9'($urandom), dbc};
  endtask

  seg_t exp_seg [$];
  logic [31:0] exp_rd [$];
  longint exp_cnt;
  logic exp_err;
  int exp_irq;

  // Reference: walk the table as described by the PRD rules, entry by entry.
  task automatic build_model(input logic [31:0] base, input logic [15:0] n);
    logic [31:0] eb, dba, d3;
    longint unsigned total, len;
    seg_t s;
    exp_seg.delete(); exp_rd.delete(); exp_cnt = 0; exp_err = 1'b0; exp_irq = 0;
    for (int i = 0; i < int'(n); i++) begin
      eb = {base[31:4], 4'h0} + 32'(i) * 32'd16;
      for (int w = 0; w < 4; w++) exp_rd.push_back(eb + 32'(4 * w));
      if (mrd(eb + 32'd4) != 32'd0) begin exp_err = 1'b1; break; end
      dba = mrd(eb) & 32'hFFFF_FFFE;
      d3 = mrd(eb + 32'd12);
      total = (longint'(d3[21:0]) | 1) + 1;
      while (total > 0) begin
        len = (total < MAXX) ? total : MAXX;
        s.addr = dba; s.len = 16'(len); s.eof = (i == int'(n) - 1) && (total <= MAXX);
        exp_seg.push_back(s);
        dba = dba + 32'(len); total -= len; exp_cnt += longint'(len);
      end
      if (d3[31]) exp_irq++;
    end
    if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
  endtask

  int s0, r0, d0, i0, rv0, dv0;
  task automatic snap();
    s0 = seg_seen.size(); r0 = rd_seen.size(); d0 = done_tot; i0 = irq_tot;
    rv0 = rd_viol; dv0 = dma_viol;
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] base, input logic [15:0] n,
                         input logic wrt, input bit restart);
    int k, bad;
    build_model(base, n);
    snap();
    @(negedge sys_clk);
    cmd_prdt_base = base; cmd_prdtl = n; cmd_wrt = wrt; cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    if (restart) begin
      repeat (3) @(negedge sys_clk);
      cmd_start = 1'b1;
      @(negedge sys_clk);
      cmd_start = 1'b0;
    end
    k = 0;
    while (cmd_done !== 1'b1 && k < LIMIT) begin @(negedge sys_clk); k++; end
    chk({tag, "_finish"}, 128'(k < LIMIT), 128'd1);
    cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    chk({tag, "_start_on_done_ignored"}, 128'(cmd_busy), 128'd0);
    repeat (3) @(negedge sys_clk);
    chk({tag, "_done_count"}, 128'(done_tot - d0), 128'd1);
    chk({tag, "_err"}, 128'(cmd_err), 128'(exp_err));
    chk({tag, "_byte_cnt"}, 128'(cmd_byte_cnt), 128'(exp_cnt));
    chk({tag, "_irq_count"}, 128'(irq_tot - i0), 128'(exp_irq));
    chk({tag, "_seg_count"}, 128'(seg_seen.size() - s0), 128'(exp_seg.size()));
    for (int i = 0; i < exp_seg.size() && s0 + i < seg_seen.size(); i++)
      chk($sformatf("%s_seg%0d", tag, i), 128'(seg_seen[s0 + i]), 128'(exp_seg[i]));
    chk({tag, "_rd_count"}, 128'(rd_seen.size() - r0), 128'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && r0 + i < rd_seen.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i), 128'(rd_seen[r0 + i]), 128'(exp_rd[i]));
    bad = 0;
    for (int i = s0; i < wrt_seen.size(); i++) if (wrt_seen[i] !== wrt) bad++;
    chk({tag, "_dma_wrt"}, 128'(bad), 128'd0);
    chk({tag, "_handshake_gap"}, 128'((rd_viol - rv0) + (dma_viol - dv0)), 128'd0);
  endtask

  initial begin
    int k, n;
    logic [31:0] base, dba;
    seg_t s;

    repeat (3) @(negedge sys_clk);
    chk_outputs_zero("in_reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_outputs_zero("after_reset");

    put_entry(32'h0000_8000, 0, 32'h0000_1000, 32'd0, 22'h1FFF, 1'b0);
    run_cmd("single", 32'h0000_8000, 16'd1, 1'b1, 1'b0);
    s.addr = 32'h1000; s.len = 16'd8192; s.eof = 1'b1;
    if (seg_seen.size() > s0) chk("single_seg_const", 128'(seg_seen[s0]), 128'(s));
    chk("single_cnt_const", 128'(cmd_byte_cnt), 128'd8192);

    put_entry(32'h0000_9000, 0, 32'h0000_1000, 32'd0, 22'h4FFF, 1'b0);
    run_cmd("split", 32'h0000_9000, 16'd1, 1'b0, 1'b0);
    chk("split_cnt_const", 128'(cmd_byte_cnt), 128'd20480);
    if (seg_seen.size() >= s0 + 3) begin
      s.addr = 32'h3000; s.len = 16'd8192; s.eof = 1'b0;
      chk("split_seg1_const", 128'(seg_seen[s0 + 1]), 128'(s));
      s.addr = 32'h5000; s.len = 16'd4096; s.eof = 1'b1;
      chk("split_seg2_const", 128'(seg_seen[s0 + 2]), 128'(s));
    end

    mem_lat_max = 2; vgap_max = 2; dma_lat_max = 3;
    put_entry(32'h0000_A000, 0, 32'h0002_0000, 32'd0, 22'h003FF, 1'b0);
    put_entry(32'h0000_A000, 1, 32'h0003_0001, 32'd0, 22'h02001, 1'b1);
    put_entry(32'h0000_A000, 2, 32'h0004_0000, 32'd0, 22'h0007F, 1'b0);
    run_cmd("multi", 32'h0000_A000, 16'd3, 1'b1, 1'b1);
    if (rd_seen.size() >= r0 + 12)
      chk("multi_last_rd_const", 128'(rd_seen[r0 + 11]), 128'h0000_A02C);

    put_entry(32'h0000_B000, 0, 32'h0005_0000, 32'd1, 22'h00FF, 1'b0);
    put_entry(32'h0000_B000, 1, 32'h0006_0000, 32'd0, 22'h00FF, 1'b0);
    run_cmd("error", 32'h0000_B000, 16'd2, 1'b0, 1'b0);
    chk("error_flag_const", 128'(cmd_err), 128'd1);

    // Abort while a segment is outstanding; the ack comes late.
    mem_lat_max = 0; vgap_max = 0; dma_fixed = 10;
    put_entry(32'h0000_C000, 0, 32'h0007_0000, 32'd0, 22'h00FF, 1'b0);
    put_entry(32'h0000_C000, 1, 32'h0008_0000, 32'd0, 22'h00FF, 1'b0);
    snap();
    @(negedge sys_clk);
    cmd_prdt_base = 32'h0000_C000; cmd_prdtl = 16'd2; cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    k = 0;
    while (dma_req !== 1'b1 && k < 200) begin @(negedge sys_clk); k++; end
    chk("abort_dma_req_seen", 128'(k < 200), 128'd1);
    cmd_abort = 1'b1;
    @(negedge sys_clk);
    cmd_abort = 1'b0;
    k = 0;
    while (cmd_done !== 1'b1 && k < 200) begin @(negedge sys_clk); k++; end
    chk("abort_finish", 128'(k < 200), 128'd1);
    @(negedge sys_clk);
    chk("abort_done_latency", 128'(done_cyc - ack_cyc), 128'd3);
    chk("abort_seg_count", 128'(seg_seen.size() - s0), 128'd1);
    chk("abort_rd_count", 128'(rd_seen.size() - r0), 128'd4);
    chk("abort_byte_cnt", 128'(cmd_byte_cnt), 128'd256);
    s.addr = 32'h0007_0000; s.len = 16'd256; s.eof = 1'b0;
    if (seg_seen.size() > s0) chk("abort_seg", 128'(seg_seen[s0]), 128'(s));
    chk("abort_done_count", 128'(done_tot - d0), 128'd1);
    dma_fixed = -1;

    // Empty table: completion without any request.
    snap();
    @(negedge sys_clk);
    cmd_prdtl = 16'd0; cmd_start = 1'b1;
    k = 0;
    do begin @(negedge sys_clk); cmd_start = 1'b0; k++; end while (cmd_done !== 1'b1 && k < 10);
    chk("empty_done_latency", 128'(k <= 3), 128'd1);
    repeat (2) @(negedge sys_clk);
    chk("empty_no_requests", 128'((rd_seen.size() - r0) + (seg_seen.size() - s0)), 128'd0);
    chk("empty_byte_cnt", 128'(cmd_byte_cnt), 128'd0);

    // Asynchronous reset while a segment is pending.
    dma_fixed = 40;
    put_entry(32'h0000_D000, 0, 32'h0009_0000, 32'd0, 22'h00FF, 1'b0);
    @(negedge sys_clk);
    cmd_prdt_base = 32'h0000_D000; cmd_prdtl = 16'd1; cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    k = 0;
    while (dma_req !== 1'b1 && k < 200) begin @(negedge sys_clk); k++; end
    chk("rst_dma_req_seen", 128'(k < 200), 128'd1);
    d0 = done_tot;
    #2 sys_rst = 1'b1;
    #1 chk_outputs_zero("async_rst");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("rst_no_done", 128'(done_tot - d0), 128'd0);
    chk_outputs_zero("rst_released");
    dma_fixed = -1;

    // Randomized tables with random memory and DMA latencies.
    mem_lat_max = 3; vgap_max = 2; dma_lat_max = 4;
    for (int r = 0; r < 8; r++) begin
      base = $urandom;
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
        dba = (r % 3 == 0) ? 32'hFFFF_E000 + 32'($urandom_range(4095, 0)) : 32'($urandom);
        put_entry(base, i, dba, ($urandom_range(7, 0) == 0) ? (32'($urandom) | 32'd1) : 32'd0,
                  (r == 5 && i == 0) ? 22'h3F_FFFF : 22'($urandom_range(24575, 0)),
                  1'($urandom));
      end
      run_cmd($sformatf("rand%0d", r), base, 16'(n), 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prd_walker.md
# prd_walker

Scatter-gather front end for the SATA DMA engine. It walks an AHCI PRD table in system memory one 16-byte entry at a time over a single-word read port. Each entry is cut into DMA segments of at most `C_MAX_XFER` bytes, and each segment is issued on the `dma_req`/`dma_ack` handshake consumed by the `dma` stage, which sits directly downstream. It keeps the running PRDBC byte count and raises per-entry and per-command completion events for the register block.

## Interface
Parameters:
- `C_MAX_XFER`, default 8192: maximum bytes per DMA segment. Power of two, 4..32768.

Ports. One clock; reset is asynchronous and active-high.
- `sys_clk`  in  1  block clock
- `sys_rst`  in  1  asynchronous active-high reset
- `cmd_start`  in  1  one-cycle pulse, start a command; ignored while `cmd_busy`
- `cmd_abort`  in  1  one-cycle pulse, abort the current command
- `cmd_prdt_base`  in  32  PRD table byte address; bits [3:0] ignored
- `cmd_prdtl`  in  16  number of PRD entries
- `cmd_wrt`  in  1  transfer direction, copied to `dma_wrt`
- `cmd_busy`  out  1  command in progress
- `cmd_done`  out  1  one-cycle completion pulse (normal, error or abort)
- `cmd_err`  out  1  sticky error flag (DBAU≠0); cleared by `cmd_start`
- `cmd_byte_cnt`  out  32  PRDBC, bytes acknowledged so far in this command
- `prd_irq`  out  1  one-cycle pulse when an entry with its I bit set completes
- `rd_req`  out  1  memory word-read request
- `rd_addr`  out  32  word address (byte address, bits [1:0]=0)
- `rd_ack`  in  1  request accepted
- `rd_valid`  in  1  read data valid
- `rd_data`  in  32  read data
- `dma_req`  out  1  segment request
- `dma_address`  out  32  segment byte address
- `dma_length`  out  16  segment byte count
- `dma_wrt`  out  1  direction
- `dma_eof`  out  1  this segment is the last of the command
- `dma_ack`  in  1  segment accepted/completed by `dma`

## Operation
FSM states: IDLE, FETCH, WAITD, CHECK, ISSUE, NEXT, FIN.
- **IDLE → FETCH** on `cmd_start`.
  - Latch base, prdtl and wrt; zero the entry index, `cmd_byte_cnt` and `cmd_err`; set `cmd_busy`.
  - If prdtl = 0, go directly to FIN.
- **FETCH:** assert `rd_req` with `rd_addr` = base + 16·idx + 4·w, for word w = 0..3.
  - Hold request and address until `rd_ack`, then go to WAITD.
- **WAITD:** on `rd_valid`, store the word.
  - w=0 → DBA (bit 0 forced 0); w=1 → DBAU; w=2 discarded; w=3 → DBC[21:0] and I = bit 31.
  - If w<3, return to FETCH with w+1; otherwise go to CHECK.
- **CHECK:**
  - If DBAU≠0: set `cmd_err`, go to FIN.
  - Otherwise remaining = {DBC[21:1],1}+1 (23-bit, always even) and addr = DBA; go to ISSUE.
- **ISSUE:** drive a segment.
  - `dma_length` = min(remaining, C_MAX_XFER); `dma_address` = addr.
  - `dma_eof` = (idx = prdtl−1) and (remaining ≤ C_MAX_XFER).
  - Hold `dma_req` until `dma_ack`. On ack: addr += len, remaining −= len, `cmd_byte_cnt` += len; go to NEXT.
- **NEXT:**
  - remaining≠0 → ISSUE.
  - Otherwise pulse `prd_irq` if I is set, increment idx, then go to FIN if idx = prdtl, else FETCH with w=0.
- **FIN:** pulse `cmd_done`, clear `cmd_busy`, go to IDLE.

Abort handling:
- `cmd_abort` sets a pending flag. It is honoured only where no handshake is outstanding: FETCH before `rd_req` is asserted, CHECK, and NEXT. The block then goes to FIN without issuing further requests.
- Outstanding `rd_req` or `dma_req` are always completed first; the WAITD data is discarded.
- Abort while IDLE is ignored.

Arithmetic and boundaries:
- Address arithmetic wraps modulo 2^32.
- `cmd_byte_cnt` saturates at 0xFFFF_FFFF.
- Entry index is 16 bits; prdtl = 0xFFFF is legal.

## Timing
- All outputs are registered. Every output resets to 0.
- `rd_req`/`dma_req` rise the cycle after the state is entered. They are held with address, length and eof stable until sampled together with ack high, and deassert the following cycle.
- No back-to-back requests: one idle cycle always separates requests.
- `rd_ack` and `rd_valid` in the same cycle are legal: the word is taken and the next FETCH proceeds.
- Minimum per-entry overhead: 4×(FETCH+WAITD) plus CHECK, i.e. ≥13 cycles with single-cycle memory.
- `cmd_done` follows the last `dma_ack` by 3 cycles (NEXT, FIN, output register).
- `cmd_start` coincident with `cmd_done` is ignored.
- Reset mid-command returns the block to IDLE immediately; no `cmd_done` is produced.

## Structure
- Shared package `sata_pkg` holds:
  - the FSM state encoding;
  - PRD entry word offsets (0, 4, 8, 12) and the entry size of 16;
  - field positions DBC = [21:0] and I = bit 31.
- One natural sub-module, `prd_seg_calc`: combinational min/eof/next-address logic, instantiated once.
- Everything else is a single FSM.

## Test plan
- **Single entry:** prdtl=1, DBA=0x1000, DBC=0x1FFF, C_MAX_XFER=8192 → one segment (0x1000, 8192, eof=1); `cmd_byte_cnt` = 8192; `cmd_done` once.
- **Split:** DBC=0x4FFF (20480 B) → segments 8192 @0x1000, 8192 @0x3000, 4096 @0x5000 (eof on the last only); byte count 20480.
- **Multi-entry with irq:** prdtl=3, I set on entry 1 only → `prd_irq` pulses once, after entry 1's last ack; `rd_addr` sequence base+0..base+44.
- **Error:** DBAU=1 on entry 0 → no `dma_req`; `cmd_err`=1; `cmd_done` pulse.
- **Abort:** pulse `cmd_abort` while `dma_req` is pending, delay `dma_ack` by 10 cycles → that segment completes, no further `rd_req`, `cmd_done` 3 cycles after the ack.
- **Edge cases:** prdtl=0 → `cmd_done` within 3 cycles of `cmd_start`, no requests. Async reset mid-ISSUE → all outputs 0 immediately.
